// File: rtl/mdu_sequencer_if.sv
// Pipeline-to-MDU connection: EX-stage start/op/operands in, stall/valid/result back.
interface mdu_sequencer_if #(
    parameter int XLEN = 32
);
    logic            start_i;
    logic [2:0]      op_i;
    logic [XLEN-1:0] rs1_i;
    logic [XLEN-1:0] rs2_i;
    logic            flush_i;
    logic            hold_i;
    logic            stall_o;
    logic            valid_o;
    logic [XLEN-1:0] result_o;

    modport master (
        output start_i, op_i, rs1_i, rs2_i, flush_i, hold_i,
        input  stall_o, valid_o, result_o
    );

    modport slave (
        input  start_i, op_i, rs1_i, rs2_i, flush_i, hold_i,
        output stall_o, valid_o, result_o
    );
endinterface

// File: rtl/mdu_sequencer.sv
// Iterative RV32M multiply/divide unit: radix-2 shift-add multiply and restoring
// divide on a shared datapath, one result per EX-stage instruction.
//
// state | meaning
// IDLE  | waiting for start; special divides resolve here in one cycle
// BUSY  | one radix-2 step per cycle, 32 steps, pipeline stalled
// DONE  | result valid; held while hold_i, then the instruction leaves EX
module mdu_sequencer #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 6
) (
    input  logic            clk_i,
    input  logic            rst_i,
    mdu_sequencer_if.slave  bus
);
    localparam int W2 = 2 * XLEN;
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(XLEN - 1);
    localparam logic [XLEN-1:0]  MOST_NEG  = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {ST_IDLE, ST_BUSY, ST_DONE} state_t;

    state_t          state_q;
    logic [W2-1:0]   acc_q;
    logic [XLEN-1:0] mcand_q;
    logic [XLEN-1:0] mplier_q;
    logic [CNT_W-1:0] cnt_q;
    logic [2:0]      op_q;
    logic            neg_q;
    logic            valid_q;
    logic [XLEN-1:0] result_q;

    // Operand decode for the start cycle
    logic            sgn_a, sgn_b, neg_start;
    logic [XLEN-1:0] mag_a, mag_b;
    logic            div_zero, div_ovf, special;
    logic [XLEN-1:0] special_res;

    always_comb begin
        sgn_a = bus.rs1_i[XLEN-1] & (bus.op_i == 3'b001 || bus.op_i == 3'b010 ||
                                     bus.op_i == 3'b100 || bus.op_i == 3'b110);
        sgn_b = bus.rs2_i[XLEN-1] & (bus.op_i == 3'b001 || bus.op_i == 3'b100 ||
                                     bus.op_i == 3'b110);
        mag_a = sgn_a ? (~bus.rs1_i + 1'b1) : bus.rs1_i;
        mag_b = sgn_b ? (~bus.rs2_i + 1'b1) : bus.rs2_i;
        // Remainder takes the dividend's sign; everything else the XOR
        neg_start = (bus.op_i[2] & bus.op_i[1]) ? sgn_a : (sgn_a ^ sgn_b);

        div_zero = bus.op_i[2] & (bus.rs2_i == '0);
        div_ovf  = bus.op_i[2] & ~bus.op_i[0] & (bus.rs1_i == MOST_NEG) & (bus.rs2_i == '1);
        special  = div_zero | div_ovf;
        if (div_zero)
            special_res = bus.op_i[1] ? bus.rs1_i : '1;
        else
            special_res = bus.op_i[1] ? '0 : MOST_NEG;
    end

    // One radix-2 step of each algorithm and the sign-corrected final result
    logic [XLEN:0]   sum_mul;
    logic [W2-1:0]   acc_mul;
    logic [XLEN:0]   rem_sh;
    logic            fits;
    logic [XLEN-1:0] rem_nxt, quot_nxt;
    logic [W2-1:0]   mag_fin, sgn_fin;
    logic [XLEN-1:0] fin_res;

    always_comb begin
        sum_mul  = {1'b0, acc_q[W2-1:XLEN]} + {1'b0, (mplier_q[0] ? mcand_q : {XLEN{1'b0}})};
        acc_mul  = {sum_mul, acc_q[XLEN-1:1]};
        rem_sh   = {acc_q[XLEN-1:0], mplier_q[XLEN-1]};
        fits     = (rem_sh >= {1'b0, mcand_q});
        rem_nxt  = fits ? (rem_sh[XLEN-1:0] - mcand_q) : rem_sh[XLEN-1:0];
        quot_nxt = {mplier_q[XLEN-2:0], fits};
        mag_fin  = op_q[2] ? {{XLEN{1'b0}}, (op_q[1] ? rem_nxt : quot_nxt)} : acc_mul;
        sgn_fin  = neg_q ? (~mag_fin + 1'b1) : mag_fin;
        fin_res  = (!op_q[2] && op_q[1:0] != 2'b00) ? sgn_fin[W2-1:XLEN] : sgn_fin[XLEN-1:0];
    end

    assign bus.stall_o  = ((state_q == ST_IDLE) & bus.start_i & ~bus.flush_i) |
                          (state_q == ST_BUSY);
    assign bus.valid_o  = valid_q;
    assign bus.result_o = result_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= ST_IDLE;
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            cnt_q    <= '0;
            op_q     <= '0;
            neg_q    <= 1'b0;
            valid_q  <= 1'b0;
            result_q <= '0;
        end else if (bus.flush_i) begin
            state_q <= ST_IDLE;
            valid_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (bus.start_i) begin
                        op_q  <= bus.op_i;
                        cnt_q <= '0;
                        if (special) begin
                            result_q <= special_res;
                            valid_q  <= 1'b1;
                            state_q  <= ST_DONE;
                        end else begin
                            acc_q    <= '0;
                            mcand_q  <= mag_b;
                            mplier_q <= mag_a;
                            neg_q    <= neg_start;
                            state_q  <= ST_BUSY;
                        end
                    end
                end
                ST_BUSY: begin
                    acc_q    <= op_q[2] ? {{XLEN{1'b0}}, rem_nxt} : acc_mul;
                    mplier_q <= op_q[2] ? quot_nxt : {1'b0, mplier_q[XLEN-1:1]};
                    cnt_q    <= cnt_q + 1'b1;
                    if (cnt_q == LAST_STEP) begin
                        result_q <= fin_res;
                        valid_q  <= 1'b1;
                        state_q  <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (!bus.hold_i) begin
                        valid_q <= 1'b0;
                        state_q <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end
endmodule
